// File: rtl/msg_pattern_generator.sv
// Avalon-ST message source: one packet of cmd_len bytes per command with a selectable data
// pattern, one-deep command buffer for back-to-back packets, and abort (truncate + flush).
module msg_pattern_generator #(
    parameter int DATA_WIDTH  = 128,
    parameter int LEN_WIDTH   = 16,
    parameter int BYTES       = DATA_WIDTH / 8,
    parameter int EMPTY_WIDTH = $clog2(DATA_WIDTH / 8)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    input  logic [1:0]             cmd_mode,
    input  logic [31:0]            cmd_seed,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    output logic                   busy,
    output logic                   msg_done,
    output logic                   msg_aborted
);

    localparam int          LANES     = DATA_WIDTH / 32;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Pending command slot
    logic                 pend_valid;
    logic [LEN_WIDTH-1:0] pend_len;
    logic [1:0]           pend_mode;
    logic [31:0]          pend_seed;

    // Active message
    logic [LEN_WIDTH-1:0]   act_words;
    logic [LEN_WIDTH-1:0]   act_idx;
    logic [1:0]             act_mode;
    logic [7:0]             act_ramp;
    logic [31:0]            act_lfsr;
    logic [EMPTY_WIDTH-1:0] act_empty;
    logic                   trunc;

    logic                   cmd_fire;
    logic                   load_avail;
    logic                   load_active;
    logic                   beat_fire;
    logic                   natural_last;
    logic                   eop_fire;
    logic                   truncated;

    logic [LEN_WIDTH-1:0]   ld_len;
    logic [LEN_WIDTH-1:0]   ld_len_eff;
    logic [1:0]             ld_mode;
    logic [31:0]            ld_seed;
    logic [LEN_WIDTH:0]     ld_round;
    logic [LEN_WIDTH:0]     ld_words_w;
    logic [LEN_WIDTH:0]     ld_span;
    logic [EMPTY_WIDTH-1:0] ld_empty;

    logic [DATA_WIDTH-1:0]  pat_data;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // Handshake: a beat (or command) transfers on a clock edge where valid & ready are both high.
    // Once out_valid rises it holds until that transfer; data/sop/empty are frozen while stalled,
    // and only a sampled abort may raise out_eop on a beat that is already being presented.
    assign cmd_ready = ~pend_valid & ~abort;
    assign cmd_fire  = cmd_valid & cmd_ready;

    assign out_valid    = (state == SEND);
    assign beat_fire    = out_valid & out_ready;
    assign natural_last = (act_idx == act_words - LEN_WIDTH'(1));
    assign eop_fire     = beat_fire & (natural_last | trunc);
    assign truncated    = trunc & ~natural_last;

    // An abort in the same cycle makes the pending slot unusable; the bypass is blocked by cmd_ready.
    assign load_avail = (pend_valid & ~abort) | cmd_fire;

    assign busy = (state == SEND) | pend_valid;

    // Load source: the pending slot has priority, otherwise the command accepted this cycle.
    always_comb begin
        ld_len  = pend_valid ? pend_len  : cmd_len;
        ld_mode = pend_valid ? pend_mode : cmd_mode;
        ld_seed = pend_valid ? pend_seed : cmd_seed;
    end

    assign ld_len_eff = (ld_len == '0) ? LEN_WIDTH'(1) : ld_len;
    assign ld_round   = {1'b0, ld_len_eff} + (LEN_WIDTH + 1)'(BYTES - 1);
    assign ld_words_w = ld_round / (LEN_WIDTH + 1)'(BYTES);
    assign ld_span    = ld_words_w * (LEN_WIDTH + 1)'(BYTES);
    assign ld_empty   = EMPTY_WIDTH'(ld_span - {1'b0, ld_len_eff});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_active = 1'b0;
        case (state)
            IDLE: begin
                if (load_avail) begin
                    load_active = 1'b1;
                    state_nxt   = SEND;
                end
            end
            SEND: begin
                if (eop_fire) begin
                    // A truncated message always returns to IDLE before the next one starts.
                    if (load_avail && !truncated) begin
                        load_active = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_len   <= '0;
            pend_mode  <= '0;
            pend_seed  <= '0;
        end else if (abort) begin
            pend_valid <= 1'b0;
        end else if (load_active && pend_valid) begin
            pend_valid <= 1'b0;
        end else if (cmd_fire && !load_active) begin
            pend_valid <= 1'b1;
            pend_len   <= cmd_len;
            pend_mode  <= cmd_mode;
            pend_seed  <= cmd_seed;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_words <= '0;
            act_idx   <= '0;
            act_mode  <= '0;
            act_ramp  <= '0;
            act_lfsr  <= '0;
            act_empty <= '0;
        end else if (load_active) begin
            act_words <= ld_words_w[LEN_WIDTH-1:0];
            act_idx   <= '0;
            act_mode  <= ld_mode;
            act_ramp  <= ld_seed[7:0];
            act_lfsr  <= (ld_seed == 32'd0) ? 32'd1 : ld_seed;
            act_empty <= ld_empty;
        end else if (beat_fire) begin
            act_idx  <= act_idx + LEN_WIDTH'(1);
            act_ramp <= act_ramp + 8'(BYTES);
            act_lfsr <= lfsr_step(act_lfsr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trunc <= 1'b0;
        end else if (eop_fire) begin
            trunc <= 1'b0;
        end else if (abort && state == SEND) begin
            trunc <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msg_done    <= 1'b0;
            msg_aborted <= 1'b0;
        end else begin
            msg_done    <= eop_fire;
            msg_aborted <= eop_fire & truncated;
        end
    end

    // Byte 0 of the beat sits in the most significant byte of out_data.
    always_comb begin
        pat_data = '0;
        case (act_mode)
            2'd1: begin
                for (int j = 0; j < BYTES; j++) begin
                    pat_data[DATA_WIDTH-1-8*j -: 8] = act_ramp + 8'(j);
                end
            end
            2'd2: begin
                for (int l = 0; l < LANES; l++) begin
                    pat_data[32*l +: 32] = act_lfsr;
                end
            end
            2'd3: begin
                for (int l = 0; l < LANES; l++) begin
                    pat_data[32*l +: 32] = 32'(act_idx);
                end
            end
            default: pat_data = '0;
        endcase
    end

    assign out_data  = out_valid ? pat_data : '0;
    assign out_sop   = out_valid & (act_idx == '0);
    assign out_eop   = out_valid & (natural_last | trunc);
    assign out_empty = (out_valid && natural_last) ? act_empty : '0;

endmodule

// File: tb/tb_msg_pattern_generator.sv
// Directed bench for msg_pattern_generator: stimulus pushes hand-computed beats into a queue,
// a negedge monitor pops and compares every transferred beat and the msg_done/msg_aborted pulses.
module tb_msg_pattern_generator;

    localparam int DW = 128;
    localparam int LW = 16;
    localparam int EW = 4;
    localparam int BW = DW + 2 + EW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len;
    logic [1:0]    cmd_mode;
    logic [31:0]   cmd_seed;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;
    logic [EW-1:0] out_empty;
    logic          busy;
    logic          msg_done;
    logic          msg_aborted;

    msg_pattern_generator #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_mode(cmd_mode), .cmd_seed(cmd_seed), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
        .busy(busy), .msg_done(msg_done), .msg_aborted(msg_aborted)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cycle = 0;
    initial forever begin
        @(posedge clk);
        cycle++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 50000", cycle);
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [BW-1:0] exp_q[$];
    logic          done_q[$];
    int            hs_q[$];
    int            checks = 0;
    int            errors = 0;

    function automatic logic [BW-1:0] beat(input logic [DW-1:0] d, input logic sop,
                                           input logic eop, input logic [EW-1:0] emp);
        return {d, sop, eop, emp};
    endfunction

    function automatic logic [DW-1:0] rep(input logic [31:0] v);
        return {4{v}};
    endfunction

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", name, got, want);
        end
    endtask

    logic [BW-1:0]      got_b;
    logic [BW-1:0]      exp_b;
    logic [DW+EW:0]     stall_d;
    logic               prev_stall   = 1'b0;
    logic               done_pending = 1'b0;
    logic               exp_ab       = 1'b0;

    initial forever begin
        @(negedge clk);
        got_b = {out_data, out_sop, out_eop, out_empty};
        if (rst) begin
            prev_stall   = 1'b0;
            done_pending = 1'b0;
        end else begin
            checks++;
            if (done_pending) begin
                if (msg_done !== 1'b1 || msg_aborted !== exp_ab) begin
                    errors++;
                    $display("FAIL msg_done: got done=%0b aborted=%0b want done=1 aborted=%0b",
                             msg_done, msg_aborted, exp_ab);
                end
                done_pending = 1'b0;
            end else if (msg_done !== 1'b0 || msg_aborted !== 1'b0) begin
                errors++;
                $display("FAIL spurious_done: got done=%0b aborted=%0b want 0 0", msg_done, msg_aborted);
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || {out_data, out_sop, out_empty} !== stall_d) begin
                    errors++;
                    $display("FAIL stall_stable: got valid=%0b %h want valid=1 %h",
                             out_valid, {out_data, out_sop, out_empty}, stall_d);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                hs_q.push_back(cycle);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %h want no beat", got_b);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (got_b !== exp_b) begin
                        errors++;
                        $display("FAIL beat: got %h want %h (data,sop,eop,empty)", got_b, exp_b);
                    end
                    if (exp_b[EW] && done_q.size() != 0) begin
                        exp_ab       = done_q.pop_front();
                        done_pending = 1'b1;
                    end
                end
            end
            prev_stall = out_valid & ~out_ready;
            stall_d    = {out_data, out_sop, out_empty};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [LW-1:0] len, input logic [1:0] mode, input logic [31:0] seed);
        logic ok;
        int   n;
        ok        = 1'b0;
        n         = 0;
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_mode  = mode;
        cmd_seed  = seed;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = cmd_ready;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        check_bit("cmd_accept", ok, 1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || done_pending) && n < 400) begin
            tick();
            n++;
        end
        check_bit({name, "_drain"}, (n < 400), 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_mode  = '0;
        cmd_seed  = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_cmd_ready", cmd_ready, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_data_zero", (out_data == '0), 1'b1);
        check_bit("rst_sop_eop", out_sop | out_eop, 1'b0);
        check_bit("rst_empty_zero", (out_empty == '0), 1'b1);
        check_bit("rst_done", msg_done | msg_aborted, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // len=64 zero pattern: 4 full beats
        out_ready = 1'b1;
        exp_q.push_back(beat('0, 1'b1, 1'b0, 4'd0));
        exp_q.push_back(beat('0, 1'b0, 1'b0, 4'd0));
        exp_q.push_back(beat('0, 1'b0, 1'b0, 4'd0));
        exp_q.push_back(beat('0, 1'b0, 1'b1, 4'd0));
        done_q.push_back(1'b0);
        send_cmd(16'd64, 2'd0, 32'h0000_1234);
        drain("zero64");

        // len=17 byte ramp from 0xF0: ramp wraps into the second beat
        exp_q.push_back(beat(128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF, 1'b1, 1'b0, 4'd0));
        exp_q.push_back(beat(128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b0, 1'b1, 4'd15));
        done_q.push_back(1'b0);
        send_cmd(16'd17, 2'd1, 32'h0000_00F0);
        drain("ramp17");

        // two queued commands, then released: three back-to-back beats
        out_ready = 1'b0;
        exp_q.push_back(beat(rep(32'd0), 1'b1, 1'b0, 4'd0));
        exp_q.push_back(beat(rep(32'd1), 1'b0, 1'b1, 4'd0));
        exp_q.push_back(beat(rep(32'd0), 1'b1, 1'b1, 4'd0));
        done_q.push_back(1'b0);
        done_q.push_back(1'b0);
        send_cmd(16'd32, 2'd3, 32'd0);
        send_cmd(16'd16, 2'd3, 32'd0);
        @(negedge clk);
        check_bit("queued_busy", busy, 1'b1);
        check_bit("queued_cmd_ready", cmd_ready, 1'b0);
        tick();
        hs_q.delete();
        out_ready = 1'b1;
        drain("b2b");
        check_bit("b2b_beat_count", (hs_q.size() == 3), 1'b1);
        if (hs_q.size() == 3) begin
            check_bit("b2b_no_bubble_01", (hs_q[1] == hs_q[0] + 1), 1'b1);
            check_bit("b2b_no_bubble_12", (hs_q[2] == hs_q[1] + 1), 1'b1);
        end

        // LFSR with seed 0 (runs from 1) under toggling backpressure
        out_ready = 1'b0;
        exp_q.push_back(beat(rep(32'h0000_0001), 1'b1, 1'b0, 4'd0));
        exp_q.push_back(beat(rep(32'h8020_0003), 1'b0, 1'b0, 4'd0));
        exp_q.push_back(beat(rep(32'hC030_0002), 1'b0, 1'b1, 4'd0));
        done_q.push_back(1'b0);
        send_cmd(16'd48, 2'd2, 32'd0);
        for (int i = 0; i < 12; i++) begin
            out_ready = ~out_ready;
            tick();
        end
        out_ready = 1'b1;
        drain("lfsr48");

        // abort while beat1 of a 10-beat message is stalled, with a command pending
        out_ready = 1'b0;
        exp_q.push_back(beat(128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b1, 1'b0, 4'd0));
        exp_q.push_back(beat(128'h10111213_14151617_18191A1B_1C1D1E1F, 1'b0, 1'b1, 4'd0));
        done_q.push_back(1'b1);
        send_cmd(16'd160, 2'd1, 32'd0);
        send_cmd(16'd32, 2'd0, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_bit("abort_valid", out_valid, 1'b1);
        check_bit("abort_eop", out_eop, 1'b1);
        check_bit("abort_empty_zero", (out_empty == '0), 1'b1);
        drain("abort");
        repeat (5) tick();
        @(negedge clk);
        check_bit("abort_idle_valid", out_valid, 1'b0);
        check_bit("abort_pending_dropped", busy, 1'b0);
        tick();

        // abort in IDLE blocks command acceptance for that cycle
        abort = 1'b1;
        @(negedge clk);
        check_bit("idle_abort_cmd_ready", cmd_ready, 1'b0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_bit("idle_after_abort_cmd_ready", cmd_ready, 1'b1);
        tick();

        // len=0 is treated as a single byte
        exp_q.push_back(beat(rep(32'd0), 1'b1, 1'b1, 4'd15));
        done_q.push_back(1'b0);
        send_cmd(16'd0, 2'd3, 32'h0000_DEAD);
        drain("len0");

        // reset in the middle of a 10-beat word-index message
        for (int w = 0; w < 10; w++) begin
            exp_q.push_back(beat(rep(32'(w)), (w == 0), (w == 9), 4'd0));
        end
        done_q.push_back(1'b0);
        send_cmd(16'd160, 2'd3, 32'd0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        done_q.delete();

        // recovery after reset
        exp_q.push_back(beat(128'h10111213_14151617_18191A1B_1C1D1E1F, 1'b1, 1'b1, 4'd0));
        done_q.push_back(1'b0);
        send_cmd(16'd16, 2'd1, 32'h0000_0010);
        drain("post_rst");

        check_bit("exp_q_empty", (exp_q.size() == 0), 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
